// File: rtl/eth_rx_addr_filter_if.sv
// eth_rx_addr_filter_if: byte stream without backpressure (data, valid, last, user).
interface eth_rx_addr_filter_if;
   logic [7:0] tdata;
   logic       tvalid;
   logic       tlast;
   logic       tuser;
   modport master (output tdata, tvalid, tlast, tuser);
   modport slave  (input  tdata, tvalid, tlast, tuser);
endinterface

// File: rtl/eth_rx_addr_filter.sv
// eth_rx_addr_filter: destination-MAC receive filter; frames are held in a fixed
// delay line long enough for the accept/drop decision to gate them at the exit.
module eth_rx_addr_filter #(
   parameter int DELAY     = 12,
   parameter int CNT_WIDTH = 16
) (
   input  logic                     rx_clk,
   input  logic                     rx_rst_n,
   eth_rx_addr_filter_if.slave      s_axis,
   eth_rx_addr_filter_if.master     m_axis,
   input  logic [47:0]              cfg_local_mac,
   input  logic                     cfg_promisc,
   input  logic                     cfg_broadcast_en,
   input  logic                     cfg_multicast_en,
   output logic [CNT_WIDTH-1:0]     stat_accepted,
   output logic [CNT_WIDTH-1:0]     stat_dropped,
   output logic                     stat_drop_pulse
);
   typedef enum logic [1:0] {IDLE, HDR, PASS, DROP} state_t;
   state_t state, state_n;
   logic [2:0] byte_cnt;
   logic [47:0] dest, dest_full;
   logic match, dec, acc, pend, gate, out_v;
   logic [DELAY-2:0][11:0] dl;
   logic ex_sof, ex_v, ex_l, ex_u;
   logic [7:0] ex_d;
   assign dest_full = {dest[39:0], s_axis.tdata};
   assign match = cfg_promisc | (dest_full == cfg_local_mac) | (&dest_full & cfg_broadcast_en) |
                  (dest_full[40] & ~&dest_full & cfg_multicast_en);
   // The output register is the last of the DELAY stages.
   assign {ex_sof, ex_v, ex_l, ex_u, ex_d} = dl[DELAY-2];
   assign out_v = ex_v & (ex_sof ? pend : gate);
   always_ff @(posedge rx_clk or negedge rx_rst_n)
      if (!rx_rst_n) state <= IDLE;
      else state <= state_n;
   always_comb begin
      state_n = state;
      dec = 1'b0;
      acc = 1'b0;
      case (state)
         IDLE: begin
            dec = s_axis.tvalid & s_axis.tlast;
            state_n = (s_axis.tvalid & ~s_axis.tlast) ? HDR : IDLE;
         end
         HDR: if (s_axis.tvalid) begin
            dec = s_axis.tlast | (byte_cnt == 3'd5);
            acc = (byte_cnt == 3'd5) & match;
            state_n = s_axis.tlast ? IDLE : (byte_cnt != 3'd5) ? HDR : match ? PASS : DROP;
         end
         default: state_n = (s_axis.tvalid & s_axis.tlast) ? IDLE : state;
      endcase
   end
   always_ff @(posedge rx_clk or negedge rx_rst_n)
      if (!rx_rst_n) begin
         byte_cnt <= 3'd0;
         dest <= 48'd0;
         pend <= 1'b0;
         gate <= 1'b0;
         dl <= '0;
         stat_accepted <= '0;
         stat_dropped <= '0;
         stat_drop_pulse <= 1'b0;
         m_axis.tvalid <= 1'b0;
         m_axis.tdata <= 8'd0;
         m_axis.tlast <= 1'b0;
         m_axis.tuser <= 1'b0;
      end else begin
         if (s_axis.tvalid & (state == IDLE | state == HDR)) begin
            dest <= (state == IDLE) ? {40'd0, s_axis.tdata} : dest_full;
            byte_cnt <= (state == IDLE) ? 3'd1 : byte_cnt + 3'd1;
         end
         if (dec) pend <= acc;
         if (dec & acc & ~&stat_accepted) stat_accepted <= stat_accepted + CNT_WIDTH'(1);
         if (dec & ~acc & ~&stat_dropped) stat_dropped <= stat_dropped + CNT_WIDTH'(1);
         stat_drop_pulse <= dec & ~acc;
         dl <= {dl[DELAY-3:0], {s_axis.tvalid & (state == IDLE), s_axis.tvalid,
                                s_axis.tlast, s_axis.tuser, s_axis.tdata}};
         if (ex_v & ex_sof) gate <= pend & ~ex_l;
         else if (ex_v & ex_l) gate <= 1'b0;
         m_axis.tvalid <= out_v;
         m_axis.tdata <= out_v ? ex_d : 8'd0;
         m_axis.tlast <= out_v & ex_l;
         m_axis.tuser <= out_v & ex_u;
      end
endmodule

// File: doc/eth_rx_addr_filter.md
ETH_RX_ADDR_FILTER -- requirements
Module: eth_rx_addr_filter

Interface
- REQ-001: Parameter DELAY, default 12, SHALL set fixed input-to-output latency in cycles; legal range 12..32.
- REQ-002: Parameter CNT_WIDTH, default 16, SHALL set width of each statistics counter.
- REQ-003: rx_clk  input  1  single clock for all logic; rising edge.
- REQ-004: rx_rst_n  input  1  reset, asynchronous assert, active-low (already decided; no synchronous-reset variant).
- REQ-005: s_axis_tdata/tvalid/tlast/tuser  input  8/1/1/1  receive byte stream from MAC; no tready, no backpressure.
- REQ-006: m_axis_tdata/tvalid/tlast/tuser  output  8/1/1/1  filtered stream; no tready.
- REQ-007: cfg_local_mac  input  48  station address; bits [47:40] compare to first destination byte on the wire.
- REQ-008: cfg_promisc, cfg_broadcast_en, cfg_multicast_en  input  1 each  acceptance enables.
- REQ-009: stat_accepted, stat_dropped  output  CNT_WIDTH each  saturating frame counters.
- REQ-010: stat_drop_pulse  output  1  one-cycle pulse per dropped frame.

Function
- REQ-011: Input stream SHALL contain at most one idle cycle between beats within a frame; frames SHALL be separated by at least 20 idle cycles.
- REQ-012: Every input beat {tvalid,tlast,tuser,tdata} SHALL traverse a DELAY-stage shift register advancing every cycle, valid or not.
- REQ-013: Parser FSM states: IDLE, HDR, PASS, DROP; IDLE on reset.
- REQ-014: IDLE: valid beat = byte 0; store to dest[47:40], byte count = 1, go HDR; if tlast on byte 0, treat as runt (REQ-018).
- REQ-015: HDR: valid beats 1..5 stored in dest bytes in wire order; decision made in cycle byte 5 is received.
- REQ-016: Accept if cfg_promisc, or dest == cfg_local_mac, or (dest == 48'hFFFFFFFFFFFF and cfg_broadcast_en), or (dest[40]==1, not broadcast, and cfg_multicast_en); else reject. Config sampled in decision cycle only.
- REQ-017: Accept -> PASS; reject -> DROP; PASS/DROP return to IDLE on valid beat with tlast; byte 5 with tlast returns directly to IDLE.
- REQ-018: tlast received before byte 5 (runt, <6 bytes) SHALL reject frame, count as dropped, return to IDLE.
- REQ-019: Decision SHALL be written to pending_accept register; SOF flag SHALL travel with byte 0 through delay line.
- REQ-020: When SOF beat exits delay line, output gate SHALL load pending_accept; gate holds until tlast beat exits.
- REQ-021: m_axis_tvalid = exiting valid AND gate (AND pending_accept on SOF cycle); tdata/tlast/tuser pass unmodified; tdata/tlast/tuser SHALL be 0 when m_axis_tvalid is 0.
- REQ-022: Accepted frame output SHALL be byte-identical and cycle-spacing-identical to input, delayed exactly DELAY cycles.
- REQ-023: Rejected frame SHALL produce no m_axis_tvalid beats.
- REQ-024: s_axis_tuser does not affect acceptance; it SHALL propagate on the tlast beat of accepted frames.
- REQ-025: stat_accepted/stat_dropped increment by 1 in decision cycle; saturate at all-ones, no wrap.
- REQ-026: stat_drop_pulse high exactly one cycle, in the decision cycle of each rejected/runt frame.

Reset
- REQ-027: Assertion of rx_rst_n low SHALL immediately clear FSM to IDLE, delay line, gate, pending_accept, dest, counters, and all outputs to 0.
- REQ-028: Frame in flight at reset SHALL be discarded entirely; no partial output after deassertion.
- REQ-029: After deassertion, next valid beat SHALL be treated as byte 0 of a new frame.

Verification
- REQ-030: cfg_local_mac=02:00:00:00:00:01, 64-byte GMII frame to that address -> identical 64 beats after 12 cycles, stat_accepted=1.
- REQ-031: Same frame to 02:00:00:00:00:02, promisc=0 -> no output beats, stat_dropped=1, one stat_drop_pulse.
- REQ-032: Broadcast frame with cfg_broadcast_en=0 then 1 -> first dropped, second passed; multicast 01:00:5E:00:00:01 follows cfg_multicast_en likewise.
- REQ-033: MII-style input (valid every other cycle), accepted 60-byte frame -> output gaps identical, latency 12; 4-byte runt -> dropped, no output.
- REQ-034: Accepted frame with tuser=1 on last beat -> output tuser=1 on last beat only; counter preset near all-ones -> saturates at 16'hFFFF.
- REQ-035: rx_rst_n pulsed low at byte 20 of accepted frame -> outputs 0 immediately, no further beats of that frame, next frame handled normally.
